integral_image_gen: RTL

Streaming integral-image generator directly upstream of haar_classifier_stage. Accepts one grayscale pixel per handshake in raster order over an IMG_WIDTH x IMG_HEIGHT window. Emits the matching integral-image value, ii(x,y) = sum of all pixels at (i,j) with i<=x and j<=y, in the same raster order. Downstream rectangle/stage logic reads its rectangle corners from this stream.

---
 rtl/haar_pkg.sv | 28 ++
 rtl/ii_line_buffer.sv | 41 ++++
 rtl/integral_image_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/haar_pkg.sv
// -----------------------------------------------------------------------------
// haar_pkg
// Shared definitions for the Haar feature front end: default window geometry,
// pixel / integral-value widths and the matching typedefs used by the blocks
// between the pixel source and haar_classifier_stage.
// -----------------------------------------------------------------------------
package haar_pkg;

   // Default detection window and pixel format.
   localparam int IMG_WIDTH_DEF  = 20;
   localparam int IMG_HEIGHT_DEF = 20;
   localparam int PIX_W_DEF      = 8;

   // Smallest integral width that holds a full window of maximum pixels.
   function automatic int sum_w_min(input int pix_w, input int width, input int height);
      return pix_w + $clog2(width * height);
   endfunction

   localparam int SUM_W_DEF = PIX_W_DEF + $clog2(IMG_WIDTH_DEF * IMG_HEIGHT_DEF);
   localparam int X_W_DEF   = $clog2(IMG_WIDTH_DEF);
   localparam int Y_W_DEF   = $clog2(IMG_HEIGHT_DEF);

   typedef logic [PIX_W_DEF-1:0] pixel_t;
   typedef logic [SUM_W_DEF-1:0] ii_t;
   typedef logic [X_W_DEF-1:0]   x_t;
   typedef logic [Y_W_DEF-1:0]   y_t;

endpackage : haar_pkg

// File: rtl/ii_line_buffer.sv
// -----------------------------------------------------------------------------
// ii_line_buffer
// One row of integral values from the previous image line. Single write port,
// single combinational read port. Reading and writing the same address in one
// cycle returns the old contents (read-before-write), which is exactly what the
// integral update needs: the value from the row above, then overwrite it.
//
// Ports
//   clk      in   write clock (rising edge)
//   wr_en    in   write strobe
//   wr_addr  in   write column
//   wr_data  in   value to store
//   rd_addr  in   read column
//   rd_data  out  stored value at rd_addr (combinational)
// -----------------------------------------------------------------------------
module ii_line_buffer #(
   parameter int DEPTH = 20,
   parameter int WIDTH = 17
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset on purpose; a reset would turn this array into
   // DEPTH*WIDTH resettable flops. Stale contents are harmless because the
   // reader masks them on the first row of every frame.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule : ii_line_buffer

// File: rtl/integral_image_gen.sv
// -----------------------------------------------------------------------------
// integral_image_gen
// Streaming integral-image generator. Takes one pixel per handshake in raster
// order over an IMG_WIDTH x IMG_HEIGHT window and emits ii(x,y), the sum of all
// pixels above and to the left (inclusive), in the same order, one cycle later.
//
// ii(x,y) = row_sum(x,y) + ii(x,y-1), where row_sum is the running sum of the
// current row; ii(x,y-1) comes from a one-row line buffer.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   pix_valid   in   pix_data valid
//   pix_ready   out  block accepts a pixel this cycle
//   pix_data    in   unsigned pixel value
//   ii_valid    out  ii_data valid
//   ii_ready    in   consumer accepts ii_data this cycle
//   ii_data     out  integral value for (ii_x, ii_y)
//   ii_x        out  column of ii_data
//   ii_y        out  row of ii_data
//   ii_last     out  high with the final coordinate of a frame
//   frame_done  out  one-cycle pulse after the ii_last output is accepted
// -----------------------------------------------------------------------------
module integral_image_gen
   import haar_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int PIX_W      = PIX_W_DEF,
   parameter int SUM_W      = SUM_W_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   input  logic [PIX_W-1:0]              pix_data,
   output logic                          ii_valid,
   input  logic                          ii_ready,
   output logic [SUM_W-1:0]              ii_data,
   output logic [$clog2(IMG_WIDTH)-1:0]  ii_x,
   output logic [$clog2(IMG_HEIGHT)-1:0] ii_y,
   output logic                          ii_last,
   output logic                          frame_done
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (SUM_W < sum_w_min(PIX_W, IMG_WIDTH, IMG_HEIGHT)) begin : g_sum_w_check
      $error("integral_image_gen: SUM_W=%0d too narrow, needs >= %0d",
             SUM_W, sum_w_min(PIX_W, IMG_WIDTH, IMG_HEIGHT));
   end

   if (IMG_WIDTH < 2 || IMG_HEIGHT < 2) begin : g_geom_check
      $error("integral_image_gen: window must be at least 2x2");
   end

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic pix_acc;
   logic out_acc;

   // A new pixel can enter whenever the single output register is empty or is
   // being drained this cycle; this keeps full 1 pixel/cycle throughput.
   assign pix_ready = !ii_valid || ii_ready;
   assign pix_acc   = pix_valid && pix_ready;
   assign out_acc   = ii_valid && ii_ready;

   // ---------------------------------------------------------------------------
   // Position counters and running row sum
   // ---------------------------------------------------------------------------
   logic [XW-1:0]    x_cnt;
   logic [YW-1:0]    y_cnt;
   logic [SUM_W-1:0] row_acc;
   logic             x_at_end;
   logic             y_at_end;

   assign x_at_end = (x_cnt == X_LAST);
   assign y_at_end = (y_cnt == Y_LAST);

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   logic [SUM_W-1:0] lb_rd_data;
   logic [SUM_W-1:0] row_acc_new;
   logic [SUM_W-1:0] above;
   logic [SUM_W-1:0] ii_new;

   // NOTE: every signal driven here gets a value first, so no path leaves it
   // unassigned and no latch can be inferred.
   always_comb begin
      row_acc_new = '0;
      above       = '0;
      ii_new      = '0;

      // Column 0 starts a fresh row sum.
      row_acc_new = ((x_cnt == '0) ? '0 : row_acc) + SUM_W'(pix_data);

      // Row 0 ignores the line buffer, which still holds the previous frame
      // (or garbage after reset).
      above  = (y_cnt == '0) ? '0 : lb_rd_data;
      ii_new = row_acc_new + above;
   end

   ii_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (SUM_W)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (pix_acc),
      .wr_addr (x_cnt),
      .wr_data (ii_new),
      .rd_addr (x_cnt),
      .rd_data (lb_rd_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         row_acc <= '0;
      end else if (pix_acc) begin
         row_acc <= row_acc_new;
         if (x_at_end) begin
            x_cnt <= '0;
            // The frame's final pixel wraps both counters, so the next pixel
            // begins a new frame with no idle cycle.
            y_cnt <= y_at_end ? '0 : y_cnt + YW'(1);
         end else begin
            x_cnt <= x_cnt + XW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ii_valid <= 1'b0;
         ii_data  <= '0;
         ii_x     <= '0;
         ii_y     <= '0;
         ii_last  <= 1'b0;
      end else if (pix_acc) begin
         // Covers the simultaneous drain-and-reload case: no bubble.
         ii_valid <= 1'b1;
         ii_data  <= ii_new;
         ii_x     <= x_cnt;
         ii_y     <= y_cnt;
         ii_last  <= x_at_end && y_at_end;
      end else if (out_acc) begin
         ii_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_acc && ii_last;
      end
   end

endmodule : integral_image_gen
